// File: rtl/reg_bank_pkg.sv
// Shared types and constants for the 8088 register-bank sequencer.
// Op codes, register codes, FSM states and byte/word helpers live here.
package reg_bank_pkg;

  typedef enum logic [1:0] {
    OP_MOV   = 2'b00,
    OP_XCHG  = 2'b01,
    OP_LOADI = 2'b10,
    OP_READ  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    REG_AX = 3'd0, REG_BX = 3'd1, REG_CX = 3'd2, REG_DX = 3'd3,
    REG_SI = 3'd4, REG_DI = 3'd5, REG_SP = 3'd6, REG_BP = 3'd7
  } reg_e;

  typedef enum logic [2:0] {
    IDLE, RD_A, RD_B, TURN, WR_A, WR_B, RESP, ERR
  } state_e;

  localparam logic SIZE_8  = 1'b0;
  localparam logic SIZE_16 = 1'b1;

  // Value as seen by the requester: byte transfers are zero-extended.
  function automatic logic [15:0] size_fit(input logic size, input logic [15:0] v);
    return (size == SIZE_16) ? v : {8'h00, v[7:0]};
  endfunction

  // Value as placed on the bank bus: byte writes carry the byte in both halves.
  function automatic logic [15:0] bus_fmt(input logic size, input logic [15:0] v);
    return (size == SIZE_16) ? v : {v[7:0], v[7:0]};
  endfunction

endpackage

// File: rtl/reg_bank_sequencer_if.sv
// Request/response channel between a requester and the register-bank sequencer.
// Handshake: a request transfers on the rising edge where req_valid & req_ready are both 1;
// the requester holds all req_* fields stable while req_valid=1 and req_ready=0.
// rsp_valid is a single-cycle pulse with no back-pressure; rsp_err qualifies it.
interface reg_bank_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic        req_size;
  logic [2:0]  req_dst;
  logic        req_dst_hl;
  logic [2:0]  req_src;
  logic        req_src_hl;
  logic [15:0] req_imm;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;

  modport master (
    output req_valid, req_op, req_size, req_dst, req_dst_hl, req_src, req_src_hl, req_imm,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_size, req_dst, req_dst_hl, req_src, req_src_hl, req_imm,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/reg_bank_bus_driver.sv
// Registered tristate driver for the shared bank data bus.
// Enable and data share one register stage so the bus turns around only on clock edges.
module reg_bank_bus_driver (
  input  logic        clk,
  input  logic        reset,
  input  logic        drive_nxt,
  input  logic [15:0] data_nxt,
  output logic        drive,
  inout  wire  [15:0] bus
);

  logic        en_q;
  logic [15:0] data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q   <= 1'b0;
      data_q <= 16'h0000;
    end else begin
      en_q   <= drive_nxt;
      data_q <= data_nxt;
    end
  end

  assign bus   = en_q ? data_q : 16'bz;
  assign drive = en_q;

endmodule

// File: rtl/reg_bank_sequencer.sv
// Bus master for the 8088 register bank: runs MOV/XCHG/LOADI/READ as read and
// write phases on the shared bank bus and returns a one-cycle response.
module reg_bank_sequencer
  import reg_bank_pkg::*;
#(
  parameter int TURN_CYC = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  reg_bank_sequencer_if.slave  host,
  output logic [2:0]           bank_select_reg,
  output logic                 bank_size,
  output logic                 bank_select_high_low,
  output logic                 bank_select_data_h_reg,
  output logic                 bank_read_write,
  inout  wire  [15:0]          bank_data,
  output state_e               dbg_state
);

  localparam bit HAS_TURN = (TURN_CYC != 0);

  state_e      state, next_state;
  op_e         op_q, cur_op;
  logic        size_q, cur_size;
  logic [2:0]  dst_q, cur_dst, src_q, cur_src;
  logic        dst_hl_q, cur_dst_hl, src_hl_q, cur_src_hl;
  logic [15:0] imm_q, cur_imm;
  logic [15:0] tmp_a, tmp_b, rd_val, fwd_a;
  logic        illegal;

  logic        ready_q, rsp_valid_q, rsp_err_q;
  logic [15:0] rsp_data_q;
  logic [2:0]  nxt_sel;
  logic        nxt_size, nxt_hl, nxt_rw, nxt_ready, nxt_rsp_valid, nxt_rsp_err;
  logic [15:0] nxt_wdata, nxt_rsp_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    // In IDLE the request fields are not latched yet, so look at them directly.
    cur_op     = op_q;
    cur_size   = size_q;
    cur_dst    = dst_q;
    cur_dst_hl = dst_hl_q;
    cur_src    = src_q;
    cur_src_hl = src_hl_q;
    cur_imm    = imm_q;
    if (state == IDLE) begin
      cur_op     = op_e'(host.req_op);
      cur_size   = host.req_size;
      cur_dst    = host.req_dst;
      cur_dst_hl = host.req_dst_hl;
      cur_src    = host.req_src;
      cur_src_hl = host.req_src_hl;
      cur_imm    = host.req_imm;
    end
    illegal = (cur_size == SIZE_8) && (cur_dst[2] || ((cur_op != OP_LOADI) && cur_src[2]));
    rd_val  = size_fit(size_q, bank_data);
    fwd_a   = (state == RD_A) ? rd_val : tmp_a;

    next_state = state;
    case (state)
      IDLE: if (host.req_valid) begin
        if (illegal)                next_state = ERR;
        else if (cur_op == OP_LOADI) next_state = WR_B;
        else                        next_state = RD_A;
      end
      RD_A: case (op_q)
        OP_XCHG: next_state = RD_B;
        OP_MOV:  next_state = HAS_TURN ? TURN : WR_B;
        default: next_state = RESP;
      endcase
      RD_B:      next_state = HAS_TURN ? TURN : WR_B;
      TURN:      next_state = WR_B;
      WR_B:      next_state = (op_q == OP_XCHG) ? WR_A : RESP;
      WR_A:      next_state = RESP;
      RESP, ERR: next_state = IDLE;
      default:   next_state = IDLE;
    endcase

    // Outputs are computed for the state being entered and registered on the same edge.
    nxt_sel       = 3'd0;
    nxt_size      = 1'b0;
    nxt_hl        = 1'b0;
    nxt_rw        = 1'b0;
    nxt_wdata     = 16'h0000;
    nxt_rsp_valid = 1'b0;
    nxt_rsp_err   = 1'b0;
    nxt_rsp_data  = 16'h0000;
    case (next_state)
      RD_A: begin
        nxt_sel  = cur_src;
        nxt_size = cur_size;
        nxt_hl   = cur_src_hl;
      end
      RD_B: begin
        nxt_sel  = cur_dst;
        nxt_size = cur_size;
        nxt_hl   = cur_dst_hl;
      end
      WR_B: begin
        nxt_sel   = cur_dst;
        nxt_size  = cur_size;
        nxt_hl    = cur_dst_hl;
        nxt_rw    = 1'b1;
        nxt_wdata = bus_fmt(cur_size, (cur_op == OP_LOADI) ? cur_imm : fwd_a);
      end
      WR_A: begin
        nxt_sel   = cur_src;
        nxt_size  = cur_size;
        nxt_hl    = cur_src_hl;
        nxt_rw    = 1'b1;
        nxt_wdata = bus_fmt(cur_size, tmp_b);
      end
      RESP: begin
        nxt_rsp_valid = 1'b1;
        if (op_q == OP_XCHG)       nxt_rsp_data = tmp_b;
        else if (op_q == OP_LOADI) nxt_rsp_data = size_fit(size_q, imm_q);
        else                       nxt_rsp_data = fwd_a;
      end
      ERR: begin
        nxt_rsp_valid = 1'b1;
        nxt_rsp_err   = 1'b1;
      end
      default: ;
    endcase
    nxt_ready = (next_state == IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q <= OP_MOV; size_q <= 1'b0; dst_q <= 3'd0; dst_hl_q <= 1'b0;
      src_q <= 3'd0; src_hl_q <= 1'b0; imm_q <= 16'h0000;
      tmp_a <= 16'h0000; tmp_b <= 16'h0000;
      ready_q <= 1'b1; rsp_valid_q <= 1'b0; rsp_err_q <= 1'b0; rsp_data_q <= 16'h0000;
      bank_select_reg <= 3'd0; bank_size <= 1'b0; bank_select_high_low <= 1'b0;
    end else begin
      if (state == IDLE && host.req_valid) begin
        op_q <= cur_op; size_q <= cur_size; dst_q <= cur_dst; dst_hl_q <= cur_dst_hl;
        src_q <= cur_src; src_hl_q <= cur_src_hl; imm_q <= cur_imm;
      end
      if (state == RD_A) tmp_a <= rd_val;
      if (state == RD_B) tmp_b <= rd_val;
      ready_q              <= nxt_ready;
      rsp_valid_q          <= nxt_rsp_valid;
      rsp_err_q            <= nxt_rsp_err;
      rsp_data_q           <= nxt_rsp_data;
      bank_select_reg      <= nxt_sel;
      bank_size            <= nxt_size;
      bank_select_high_low <= nxt_hl;
    end
  end

  reg_bank_bus_driver u_drv (
    .clk       (clk),
    .reset     (reset),
    .drive_nxt (nxt_rw),
    .data_nxt  (nxt_wdata),
    .drive     (bank_read_write),
    .bus       (bank_data)
  );

  assign host.req_ready         = ready_q;
  assign host.rsp_valid         = rsp_valid_q;
  assign host.rsp_err           = rsp_err_q;
  assign host.rsp_data          = rsp_data_q;
  assign bank_select_data_h_reg = 1'b0;
  assign dbg_state              = state;

endmodule

// File: tb/tb_reg_bank_sequencer.sv
// Bench for reg_bank_sequencer: behavioural register bank on the tristate bus,
// a vector table of requests with expected responses, and corner-case sequences.
module tb_reg_bank_sequencer;
  import reg_bank_pkg::*;

  localparam int T = 1;

  typedef struct {
    logic [1:0]  op;
    logic        size;
    logic [2:0]  dst;
    logic        dst_hl;
    logic [2:0]  src;
    logic        src_hl;
    logic [15:0] imm;
    logic        err;
    logic [15:0] exp;
  } vec_t;

  typedef struct packed {
    logic        err;
    logic [15:0] data;
    logic [31:0] at;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] cyc = 32'd0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  // ---------------- DUT and bank model ----------------
  reg_bank_sequencer_if host ();
  wire  [15:0] bank_data;
  logic [2:0]  bank_select_reg;
  logic        bank_size, bank_select_high_low, bank_select_data_h_reg, bank_read_write;
  state_e      dbg_state;

  reg_bank_sequencer #(.TURN_CYC(T)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .host                   (host),
    .bank_select_reg        (bank_select_reg),
    .bank_size              (bank_size),
    .bank_select_high_low   (bank_select_high_low),
    .bank_select_data_h_reg (bank_select_data_h_reg),
    .bank_read_write        (bank_read_write),
    .bank_data              (bank_data),
    .dbg_state              (dbg_state)
  );

  logic [15:0] bank_q [8];
  logic [15:0] bank_out;
  logic [7:0]  byte_sel;

  always_comb begin
    byte_sel = bank_select_high_low ? bank_q[bank_select_reg][15:8] : bank_q[bank_select_reg][7:0];
    bank_out = bank_size ? bank_q[bank_select_reg] : {byte_sel, byte_sel};
  end

  assign bank_data = bank_read_write ? 16'bz : bank_out;

  always @(posedge clk) begin
    if (bank_read_write) begin
      if (bank_size)                 bank_q[bank_select_reg]       <= bank_data;
      else if (bank_select_high_low) bank_q[bank_select_reg][15:8] <= bank_data[15:8];
      else                           bank_q[bank_select_reg][7:0]  <= bank_data[7:0];
    end
  end

  // ---------------- scoreboard ----------------
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t exp_q [$];
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      check("h_reg_zero", {31'd0, bank_select_data_h_reg}, 32'd0);
      if (!bank_read_write) check("bus_bank_only", {16'd0, bank_data}, {16'd0, bank_out});
      if (host.rsp_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL rsp_unexpected: got data %h err %b expected no response", host.rsp_data, host.rsp_err);
        end else begin
          mon_e = exp_q.pop_front();
          check("rsp_err", {31'd0, host.rsp_err}, {31'd0, mon_e.err});
          if (!mon_e.err) check("rsp_data", {16'd0, host.rsp_data}, {16'd0, mon_e.data});
          check("rsp_cycle", cyc, mon_e.at);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic int lat_of(input vec_t v);
    if (v.err) return 1;
    case (v.op)
      OP_MOV:  return 3 + T;
      OP_XCHG: return 5 + T;
      default: return 2;
    endcase
  endfunction

  function automatic vec_t mk(input logic [1:0] op, input logic size, input logic [2:0] dst,
                              input logic dhl, input logic [2:0] src, input logic shl,
                              input logic [15:0] imm, input logic err, input logic [15:0] exp);
    vec_t v;
    v.op = op; v.size = size; v.dst = dst; v.dst_hl = dhl; v.src = src; v.src_hl = shl;
    v.imm = imm; v.err = err; v.exp = exp;
    return v;
  endfunction

  task automatic drive_fields(input vec_t v);
    host.req_op     = v.op;
    host.req_size   = v.size;
    host.req_dst    = v.dst;
    host.req_dst_hl = v.dst_hl;
    host.req_src    = v.src;
    host.req_src_hl = v.src_hl;
    host.req_imm    = v.imm;
    host.req_valid  = 1'b1;
  endtask

  task automatic issue(input vec_t v, input bit hold, output logic [31:0] acc);
    int   n;
    exp_t ne;
    drive_fields(v);
    n = 0;
    while (!host.req_ready && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    acc = 32'd0;
    if (!host.req_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: req_ready stayed 0 expected 1");
      host.req_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      acc     = cyc;
      ne.err  = v.err;
      ne.data = v.exp;
      ne.at   = acc + 32'(lat_of(v)) - 32'd1;
      exp_q.push_back(ne);
      if (!hold) host.req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL rsp_timeout: %0d responses outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- test ----------------
  vec_t        tbl [25];
  logic [15:0] final_exp [8];
  logic [31:0] acc0, acc1, acc2;
  vec_t        va, vb, vc;

  initial begin
    host.req_valid = 1'b0; host.req_op = 2'b00; host.req_size = 1'b0; host.req_dst = 3'd0;
    host.req_dst_hl = 1'b0; host.req_src = 3'd0; host.req_src_hl = 1'b0; host.req_imm = 16'h0;

    tbl[0]  = mk(OP_LOADI, SIZE_16, REG_BX, 0, REG_AX, 0, 16'h1234, 0, 16'h1234);
    tbl[1]  = mk(OP_READ,  SIZE_16, REG_AX, 0, REG_BX, 0, 16'h0000, 0, 16'h1234);
    tbl[2]  = mk(OP_LOADI, SIZE_16, REG_AX, 0, REG_AX, 0, 16'hA5C3, 0, 16'hA5C3);
    tbl[3]  = mk(OP_LOADI, SIZE_16, REG_DX, 0, REG_AX, 0, 16'h7788, 0, 16'h7788);
    tbl[4]  = mk(OP_MOV,   SIZE_8,  REG_DX, 1, REG_AX, 0, 16'h0000, 0, 16'h00C3);
    tbl[5]  = mk(OP_READ,  SIZE_16, REG_AX, 0, REG_DX, 0, 16'h0000, 0, 16'hC388);
    tbl[6]  = mk(OP_LOADI, SIZE_16, REG_CX, 0, REG_AX, 0, 16'h1111, 0, 16'h1111);
    tbl[7]  = mk(OP_LOADI, SIZE_16, REG_SI, 0, REG_AX, 0, 16'h2222, 0, 16'h2222);
    tbl[8]  = mk(OP_XCHG,  SIZE_16, REG_CX, 0, REG_SI, 0, 16'h0000, 0, 16'h1111);
    tbl[9]  = mk(OP_READ,  SIZE_16, REG_AX, 0, REG_CX, 0, 16'h0000, 0, 16'h2222);
    tbl[10] = mk(OP_READ,  SIZE_16, REG_AX, 0, REG_SI, 0, 16'h0000, 0, 16'h1111);
    tbl[11] = mk(OP_MOV,   SIZE_8,  REG_DI, 0, REG_AX, 0, 16'h0000, 1, 16'h0000);
    tbl[12] = mk(OP_READ,  SIZE_8,  REG_AX, 0, REG_SI, 0, 16'h0000, 1, 16'h0000);
    tbl[13] = mk(OP_LOADI, SIZE_8,  REG_BX, 1, REG_AX, 0, 16'hFF5A, 0, 16'h005A);
    tbl[14] = mk(OP_READ,  SIZE_16, REG_AX, 0, REG_BX, 0, 16'h0000, 0, 16'h5A34);
    tbl[15] = mk(OP_XCHG,  SIZE_8,  REG_AX, 1, REG_AX, 0, 16'h0000, 0, 16'h00A5);
    tbl[16] = mk(OP_READ,  SIZE_16, REG_AX, 0, REG_AX, 0, 16'h0000, 0, 16'hC3A5);
    tbl[17] = mk(OP_MOV,   SIZE_16, REG_SP, 0, REG_SI, 0, 16'h0000, 0, 16'h1111);
    tbl[18] = mk(OP_LOADI, SIZE_16, REG_BP, 0, REG_AX, 0, 16'hBEEF, 0, 16'hBEEF);
    tbl[19] = mk(OP_XCHG,  SIZE_16, REG_BP, 0, REG_BP, 0, 16'h0000, 0, 16'hBEEF);
    tbl[20] = mk(OP_READ,  SIZE_16, REG_AX, 0, REG_BP, 0, 16'h0000, 0, 16'hBEEF);
    tbl[21] = mk(OP_LOADI, SIZE_8,  REG_SP, 0, REG_AX, 0, 16'h0099, 1, 16'h0000);
    tbl[22] = mk(OP_MOV,   SIZE_16, REG_DI, 0, REG_DX, 0, 16'h0000, 0, 16'hC388);
    tbl[23] = mk(OP_LOADI, SIZE_8,  REG_CX, 0, REG_BP, 0, 16'h0042, 0, 16'h0042);
    tbl[24] = mk(OP_READ,  SIZE_16, REG_AX, 0, REG_CX, 0, 16'h0000, 0, 16'h2242);

    final_exp[0] = 16'hC3A5; final_exp[1] = 16'h5A34; final_exp[2] = 16'h2242; final_exp[3] = 16'hC388;
    final_exp[4] = 16'h1111; final_exp[5] = 16'hC388; final_exp[6] = 16'h1111; final_exp[7] = 16'hBEEF;

    // Reset values.
    #12;
    check("rst_req_ready", {31'd0, host.req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, host.rsp_valid}, 32'd0);
    check("rst_rsp_data", {16'd0, host.rsp_data}, 32'd0);
    check("rst_rsp_err", {31'd0, host.rsp_err}, 32'd0);
    check("rst_rw", {31'd0, bank_read_write}, 32'd0);
    check("rst_sel", {29'd0, bank_select_reg}, 32'd0);
    check("rst_size_hl", {30'd0, bank_size, bank_select_high_low}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // Vector table.
    for (int i = 0; i < 25; i++) begin
      issue(tbl[i], 1'b0, acc0);
      drain();
    end
    for (int r = 0; r < 8; r++) check($sformatf("bank_after_table_%0d", r), {16'd0, bank_q[r]}, {16'd0, final_exp[r]});

    // Illegal request: no bank write phase may appear.
    va = mk(OP_MOV, SIZE_8, REG_DI, 0, REG_AX, 0, 16'h0000, 1, 16'h0000);
    issue(va, 1'b0, acc0);
    for (int k = 0; k < 3; k++) begin
      check("err_no_write", {31'd0, bank_read_write}, 32'd0);
      @(posedge clk); #1;
    end
    drain();

    // Reset while XCHG sits in RD_B: no response, bank untouched.
    va = mk(OP_XCHG, SIZE_16, REG_CX, 0, REG_SI, 0, 16'h0000, 0, 16'h0000);
    drive_fields(va);
    @(posedge clk); #1;
    host.req_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_xchg_state", {29'd0, dbg_state}, {29'd0, RD_B});
    reset = 1'b1;
    #1;
    check("mid_rst_ready", {31'd0, host.req_ready}, 32'd1);
    check("mid_rst_rw", {31'd0, bank_read_write}, 32'd0);
    check("mid_rst_rsp_valid", {31'd0, host.rsp_valid}, 32'd0);
    check("mid_rst_state", {29'd0, dbg_state}, {29'd0, IDLE});
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    for (int r = 0; r < 8; r++) check($sformatf("bank_after_reset_%0d", r), {16'd0, bank_q[r]}, {16'd0, final_exp[r]});

    // Back-to-back with req_valid held high.
    va = mk(OP_MOV,  SIZE_16, REG_BP, 0, REG_CX, 0, 16'h0000, 0, 16'h2242);
    vb = mk(OP_READ, SIZE_16, REG_AX, 0, REG_BP, 0, 16'h0000, 0, 16'h2242);
    vc = mk(OP_XCHG, SIZE_16, REG_SP, 0, REG_DI, 0, 16'h0000, 0, 16'h1111);
    issue(va, 1'b1, acc0);
    issue(vb, 1'b1, acc1);
    issue(vc, 1'b0, acc2);
    check("b2b_gap_1", acc1 - acc0, 32'(lat_of(va) + 1));
    check("b2b_gap_2", acc2 - acc1, 32'(lat_of(vb) + 1));
    drain();
    check("b2b_sp", {16'd0, bank_q[REG_SP]}, 32'h0000C388);
    check("b2b_di", {16'd0, bank_q[REG_DI]}, 32'h00001111);
    check("b2b_bp", {16'd0, bank_q[REG_BP]}, 32'h00002242);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_bank_sequencer.md
Name: reg_bank_sequencer

Overview:
Bus master for the 8088 register bank. It accepts register-transfer requests (MOV, XCHG, LOADI, READ) over a valid/ready handshake and sequences them as single-cycle read and write phases on the bank's shared tristate data bus. It owns the bank's control signals (select, size, high/low, read/write). It returns a one-cycle response carrying the data moved or read.

Parameters:
TURN_CYC, 1, idle cycles inserted between a read phase and the following write phase (0 or 1); bus released to the bank during these cycles.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  high only in IDLE
req_op  in  2  00 MOV (dst<-src), 01 XCHG (dst<->src), 10 LOADI (dst<-imm), 11 READ (rsp<-src)
req_size  in  1  1: 16-bit, 0: 8-bit
req_dst  in  3  destination code: 0 AX,1 BX,2 CX,3 DX,4 SI,5 DI,6 SP,7 BP
req_dst_hl  in  1  8-bit only: 1 high byte, 0 low byte
req_src  in  3  source code, same encoding as req_dst
req_src_hl  in  1  8-bit only: source high/low byte
req_imm  in  16  LOADI immediate; 8-bit uses [7:0]
rsp_valid  out  1  one-cycle response pulse
rsp_data  out  16  MOV: moved value; XCHG: old dst value; LOADI: imm; READ: src value; 8-bit zero-extended
rsp_err  out  1  qualifies rsp_valid; illegal request
bank_select_reg  out  3  to bank select_reg
bank_size  out  1  to bank size
bank_select_high_low  out  1  to bank select_high_low
bank_select_data_h_reg  out  1  to bank select_data_h_reg; always 0
bank_read_write  out  1  0 read (bank drives bus), 1 write (sequencer drives bus)
bank_data  inout  16  shared bus; driven only while bank_read_write=1, else Z

Behaviour:
- Reset (asynchronous, any state):
  - State returns to IDLE; in-flight request dropped, no response.
  - Outputs: req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, bank_read_write=0, bank_data=Z, bank selects=0.
  - Internal latches tmp_a and tmp_b cleared.
- All outputs are registered (bank_data driver enable = registered bank_read_write), so the bus never sees two drivers.
- Request acceptance:
  - Accept on the edge where req_valid & req_ready; latch all req_* fields.
  - req_ready=0 from the following cycle until the cycle after rsp_valid.
- Illegal request: req_size=0 with req_dst[2]=1, or with req_src[2]=1 for MOV/XCHG/READ.
  - Response: state ERR, then rsp_valid=1 and rsp_err=1 in the cycle after acceptance.
  - No bank access in that case.
- Phases:
  - RD_x: drive selects for x, bank_read_write=0; capture bank_data at the phase's closing edge. 8-bit uses bits [7:0], zero-extended.
  - WR_x: drive selects, bank_read_write=1, bank_data = value. 8-bit duplicates the byte in both halves. The bank writes on the phase's closing edge.
- States: IDLE, RD_A, RD_B, TURN, WR_A, WR_B, RESP, ERR.
- Sequences, from the accept edge, with T = TURN_CYC:
  - MOV: RD_A(src) -> TURN×T -> WR_B(dst, tmp_a) -> RESP. rsp_valid in cycle 3+T.
  - XCHG: RD_A(src) -> RD_B(dst) -> TURN×T -> WR_B(dst, tmp_a) -> WR_A(src, tmp_b) -> RESP. rsp_valid in cycle 5+T.
  - LOADI: WR_B(dst, imm) -> RESP. rsp_valid in cycle 2; no TURN.
  - READ: RD_A(src) -> RESP. rsp_valid in cycle 2; no bank write.
- RESP: rsp_valid=1 for exactly one cycle, bank bus released; then IDLE. A new request may be accepted in the cycle after RESP.
- src == dst (including same byte): the sequence still runs. Register value is unchanged; rsp_data reflects the value read.
- Idle bus state: bank_read_write=0 (bank drives its current mux output); sequencer never drives.

Decomposition:
- reg_bank_pkg holds:
  - op codes: OP_MOV, OP_XCHG, OP_LOADI, OP_READ
  - register codes: REG_AX..REG_BP
  - FSM state enumeration
  - SIZE_8 / SIZE_16 constants
- One sub-module, reg_bank_bus_driver: registered tristate driver (data, enable) for bank_data, so the drive-enable timing lives in one place.
- FSM and datapath stay in the top.

Test Plan:
1. Reset mid-XCHG (assert reset in RD_B) -> bank_data=Z, bank_read_write=0, and req_ready=1 immediately; no rsp_valid; bank registers unmodified.
2. LOADI 16-bit dst=BX imm=16'h1234, then READ src=BX -> LOADI rsp at cycle 2 with rsp_data=16'h1234; READ rsp_data=16'h1234, rsp_err=0.
3. AX=16'hA5C3, MOV 8-bit dst=DH src=AL, TURN_CYC=1 -> rsp in cycle 4 with rsp_data=16'h00C3; DX[15:8]=8'hC3, DX[7:0] unchanged.
4. CX=16'h1111, SI=16'h2222, XCHG dst=CX src=SI -> rsp_data=16'h1111; then CX=16'h2222, SI=16'h1111; rsp in cycle 6 (TURN_CYC=1) or cycle 5 (TURN_CYC=0).
5. MOV 8-bit dst code 5 -> rsp_valid=1 and rsp_err=1 in cycle 1; bank_read_write stays 0 throughout.
6. Back-to-back requests with req_valid held high -> second request accepted exactly one cycle after the first rsp_valid; the bus is never driven by both sides (monitor checks bank_data drive vs bank_read_write every cycle).
